// File: rtl/sram_write_buffer_if.sv
// Byte-in / SRAM-write handshake bundle for sram_write_buffer.
interface sram_write_buffer_if;
  logic [7:0]  BYTE_IN;
  logic        BYTE_VALID;
  logic        BYTE_READY;
  logic        FLUSH;
  logic [15:0] DATA_WRITE;
  logic        WRITE_CMD;
  logic        WRITE_DONE;
  logic [17:0] WRITE_ADDRESS;
  logic        MEM_FULL;
  logic        OVERFLOW;
  logic        WRITE_ERROR;

  modport slave (
    input  BYTE_IN, BYTE_VALID, FLUSH, WRITE_DONE,
    output BYTE_READY, DATA_WRITE, WRITE_CMD, WRITE_ADDRESS,
           MEM_FULL, OVERFLOW, WRITE_ERROR
  );

  modport master (
    output BYTE_IN, BYTE_VALID, FLUSH, WRITE_DONE,
    input  BYTE_READY, DATA_WRITE, WRITE_CMD, WRITE_ADDRESS,
           MEM_FULL, OVERFLOW, WRITE_ERROR
  );
endinterface

// File: rtl/sram_write_buffer.sv
// Packs telemetry bytes into 16-bit words (low byte first), queues them in a
// small FIFO and writes them to SRAM through a cmd/ack handshake with retry.
module sram_write_buffer #(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned WR_GAP      = 4,
  parameter int unsigned ACK_TIMEOUT = 255,
  parameter logic [17:0] ADDR_LAST   = 18'h3FFFF
) (
  input logic                CLK_48MHZ,
  input logic                RESET,
  sram_write_buffer_if.slave sif
);
  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam int unsigned TW = $clog2(ACK_TIMEOUT + 1) + 1;
  localparam int unsigned GW = 16;

  typedef enum logic [1:0] {IDLE, CMD, WAIT, GAP} state_t;

  // GAP + IDLE + CMD together make up the WR_GAP low cycles of WRITE_CMD,
  // so GAP itself is skipped for WR_GAP<=2 and WR_GAP==1 reloads straight to CMD.
  localparam state_t GAP_ENTRY = (WR_GAP >= 3) ? GAP : IDLE;

  state_t          state_q, state_d;
  logic [15:0]     data_q, data_d;
  logic            cmd_q, cmd_d;
  logic [17:0]     addr_q, addr_d;
  logic            mem_full_q, mem_full_d;
  logic            overflow_q, overflow_d;
  logic            werr_q, werr_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic            half_q, half_d;
  logic [7:0]      low_q, low_d;
  logic            flush_pend_q, flush_pend_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [15:0]     mem_q [FIFO_DEPTH];
  logic [15:0]     mem_d [FIFO_DEPTH];

  logic            fifo_full, fifo_empty, byte_ready, accept;
  logic            push, pop, do_push, flush_req;
  logic [15:0]     push_data;

  assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign byte_ready = !fifo_full && !mem_full_q && !RESET;
  assign accept     = sif.BYTE_VALID && byte_ready;

  assign sif.BYTE_READY    = byte_ready;
  assign sif.DATA_WRITE    = data_q;
  assign sif.WRITE_CMD     = cmd_q;
  assign sif.WRITE_ADDRESS = addr_q;
  assign sif.MEM_FULL      = mem_full_q;
  assign sif.OVERFLOW      = overflow_q;
  assign sif.WRITE_ERROR   = werr_q;

  // Byte packer and flush: an accepted byte is packed first, flush acts on the result.
  always_comb begin
    half_d       = half_q;
    low_d        = low_q;
    flush_pend_d = flush_pend_q;
    push         = 1'b0;
    push_data    = '0;
    flush_req    = sif.FLUSH || flush_pend_q;
    if (accept) begin
      if (half_q) begin
        push      = 1'b1;
        push_data = {sif.BYTE_IN, low_q};
        half_d    = 1'b0;
      end else begin
        low_d  = sif.BYTE_IN;
        half_d = 1'b1;
      end
    end
    if (flush_req) begin
      if (half_d && !push) begin
        if (!fifo_full) begin
          push         = 1'b1;
          push_data    = {8'h00, low_d};
          half_d       = 1'b0;
          flush_pend_d = 1'b0;
        end else begin
          flush_pend_d = 1'b1;
        end
      end else begin
        flush_pend_d = 1'b0;
      end
    end
  end

  // Word FIFO; emptied and frozen once memory is full.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_push  = push && !mem_full_q && (!fifo_full || pop);
    if (mem_full_q) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + CW'(do_push) - CW'(pop);
    end
  end

  // Write FSM: next state, handshake outputs and sticky flags.
  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    cmd_d      = cmd_q;
    addr_d     = addr_q;
    mem_full_d = mem_full_q;
    werr_d     = werr_q;
    tmo_d      = tmo_q;
    gap_d      = gap_q;
    pop        = 1'b0;
    overflow_d = overflow_q || (mem_full_q && sif.BYTE_VALID);
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty && !mem_full_q) begin
          data_d  = mem_q[rd_ptr_q];
          state_d = CMD;
        end
      end
      CMD: begin
        cmd_d   = 1'b1;
        tmo_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (sif.WRITE_DONE) begin
          pop     = 1'b1;
          cmd_d   = 1'b0;
          gap_d   = '0;
          state_d = GAP_ENTRY;
          if (addr_q == ADDR_LAST) begin
            mem_full_d = 1'b1;
          end else begin
            addr_d = addr_q + 18'd1;
            if (WR_GAP == 1 && count_q >= CW'(2)) begin
              data_d  = mem_q[rd_ptr_q + AW'(1)];
              state_d = CMD;
            end
          end
        end else if (tmo_q == TW'(ACK_TIMEOUT)) begin
          werr_d  = 1'b1;
          cmd_d   = 1'b0;
          gap_d   = '0;
          state_d = (WR_GAP == 1) ? CMD : GAP_ENTRY;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      GAP: begin
        if (gap_q == GW'(WR_GAP - 3)) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge CLK_48MHZ) begin
    if (RESET) begin
      state_q      <= IDLE;
      data_q       <= '0;
      cmd_q        <= 1'b0;
      addr_q       <= '0;
      mem_full_q   <= 1'b0;
      overflow_q   <= 1'b0;
      werr_q       <= 1'b0;
      tmo_q        <= '0;
      gap_q        <= '0;
      half_q       <= 1'b0;
      low_q        <= '0;
      flush_pend_q <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      mem_q        <= '{default: '0};
    end else begin
      state_q      <= state_d;
      data_q       <= data_d;
      cmd_q        <= cmd_d;
      addr_q       <= addr_d;
      mem_full_q   <= mem_full_d;
      overflow_q   <= overflow_d;
      werr_q       <= werr_d;
      tmo_q        <= tmo_d;
      gap_q        <= gap_d;
      half_q       <= half_d;
      low_q        <= low_d;
      flush_pend_q <= flush_pend_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      mem_q        <= mem_d;
    end
  end
endmodule

// File: tb/tb_sram_write_buffer.sv
// Scoreboard bench: expected SRAM writes are queued by the stimulus thread and
// checked by a monitor on every WRITE_CMD rising edge.
`timescale 1ns/1ps
module tb_sram_write_buffer;
  localparam int unsigned FIFO_DEPTH  = 4;
  localparam int unsigned WR_GAP      = 4;
  localparam int unsigned ACK_TIMEOUT = 255;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic       rst_a, rst_b, sel;
  logic [7:0] byte_in;
  logic       byte_valid, flush, done;

  sram_write_buffer_if bus_a ();
  sram_write_buffer_if bus_b ();

  assign bus_a.BYTE_IN    = byte_in;
  assign bus_a.BYTE_VALID = byte_valid;
  assign bus_a.FLUSH      = flush;
  assign bus_a.WRITE_DONE = done & !sel;
  assign bus_b.BYTE_IN    = byte_in;
  assign bus_b.BYTE_VALID = byte_valid;
  assign bus_b.FLUSH      = flush;
  assign bus_b.WRITE_DONE = done & sel;

  sram_write_buffer #(
    .FIFO_DEPTH(FIFO_DEPTH), .WR_GAP(WR_GAP), .ACK_TIMEOUT(ACK_TIMEOUT), .ADDR_LAST(18'h3FFFF)
  ) dut_a (.CLK_48MHZ(clk), .RESET(rst_a), .sif(bus_a));

  sram_write_buffer #(
    .FIFO_DEPTH(FIFO_DEPTH), .WR_GAP(WR_GAP), .ACK_TIMEOUT(ACK_TIMEOUT), .ADDR_LAST(18'd3)
  ) dut_b (.CLK_48MHZ(clk), .RESET(rst_b), .sif(bus_b));

  // Outputs of whichever DUT is currently under test
  logic        rst, cmd, ready, mfull, ovf, werr;
  logic [15:0] wdata;
  logic [17:0] waddr;
  assign rst   = sel ? rst_b : rst_a;
  assign cmd   = sel ? bus_b.WRITE_CMD     : bus_a.WRITE_CMD;
  assign ready = sel ? bus_b.BYTE_READY    : bus_a.BYTE_READY;
  assign mfull = sel ? bus_b.MEM_FULL      : bus_a.MEM_FULL;
  assign ovf   = sel ? bus_b.OVERFLOW      : bus_a.OVERFLOW;
  assign werr  = sel ? bus_b.WRITE_ERROR   : bus_a.WRITE_ERROR;
  assign wdata = sel ? bus_b.DATA_WRITE    : bus_a.DATA_WRITE;
  assign waddr = sel ? bus_b.WRITE_ADDRESS : bus_a.WRITE_ADDRESS;

  int          errors = 0;
  int          checks = 0;
  bit          ack_en;
  int          ack_delay = 3;
  bit          gap_chk;
  logic [33:0] exp_q [$];   // {addr[17:0], data[15:0]}

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Memory controller model: one-cycle WRITE_DONE ack_delay cycles after WRITE_CMD rises
  initial begin : ctrl
    int age;
    age  = 0;
    done = 1'b0;
    forever begin
      @(negedge clk);
      done = 1'b0;
      if (rst || !cmd) begin
        age = 0;
      end else begin
        age++;
        if (ack_en && age >= ack_delay) done = 1'b1;
      end
    end
  end

  // Monitor: each WRITE_CMD rise must match the head of the expected-write queue
  initial begin : monitor
    logic        prev;
    bit          have_prev;
    int          low_cnt;
    logic [33:0] e;
    prev = 1'b0; have_prev = 1'b0; low_cnt = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev = 1'b0; have_prev = 1'b0; low_cnt = 0;
      end else begin
        if (cmd && !prev) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: got addr=%0d data=%h, required no write", waddr, wdata);
          end else begin
            e = exp_q.pop_front();
            chk("wr_data", 32'(wdata), 32'(e[15:0]));
            chk("wr_addr", 32'(waddr), 32'(e[33:16]));
          end
          if (gap_chk && have_prev) chk("wr_gap_len", 32'(low_cnt), 32'(WR_GAP));
          have_prev = 1'b1;
        end
        if (cmd) low_cnt = 0;
        else     low_cnt++;
        prev = cmd;
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b);
    int n;
    @(negedge clk);
    byte_in    = b;
    byte_valid = 1'b1;
    n = 0;
    while (!ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) chk("send_ready_timeout", 32'(n), 32'(0));
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic pulse_flush();
    @(negedge clk);
    byte_valid = 1'b0;
    flush      = 1'b1;
    @(negedge clk);
    flush      = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || cmd) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk({"drain_done_", tag}, 32'(n < 3000), 32'(1));
    repeat (WR_GAP + 2) @(negedge clk);
  endtask

  initial begin : stim
    int n;
    int hi;
    byte_in = '0; byte_valid = 1'b0; flush = 1'b0;
    rst_a = 1'b1; rst_b = 1'b1; sel = 1'b0;
    ack_en = 1'b1; gap_chk = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(ready), 32'(0));
    chk("rst_cmd", 32'(cmd), 32'(0));
    chk("rst_addr", 32'(waddr), 32'(0));
    chk("rst_flags", 32'({mfull, ovf, werr}), 32'(0));
    rst_a = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 32'(ready), 32'(1));

    // Two words, latency and inter-write gap
    gap_chk = 1'b1;
    exp_q.push_back({18'd0, 16'h1234});
    exp_q.push_back({18'd1, 16'h5678});
    send_byte(8'h34);
    send_byte(8'h12);
    idle();
    chk("latency_n0", 32'(cmd), 32'(0));
    @(negedge clk);
    chk("latency_n1", 32'(cmd), 32'(0));
    @(negedge clk);
    chk("latency_n2", 32'(cmd), 32'(1));
    send_byte(8'h78);
    send_byte(8'h56);
    idle();
    drain("t1");
    chk("t1_addr", 32'(waddr), 32'(2));
    gap_chk = 1'b0;

    // Odd byte flushed with zero padding; flush without partial byte is a no-op
    exp_q.push_back({18'd2, 16'h00AB});
    send_byte(8'hAB);
    pulse_flush();
    drain("t2");
    chk("t2_addr", 32'(waddr), 32'(3));
    pulse_flush();
    repeat (20) @(negedge clk);
    chk("t2_noop_cmd", 32'(cmd), 32'(0));
    chk("t2_noop_addr", 32'(waddr), 32'(3));

    // Back-pressure with acks withheld, then in-order drain
    ack_en = 1'b0;
    for (int i = 0; i < 5; i++)
      exp_q.push_back({18'(3 + i), 8'(8'h11 + 2 * i), 8'(8'h10 + 2 * i)});
    for (int i = 0; i < 8; i++) send_byte(8'(8'h10 + i));
    idle();
    chk("t3_full_ready", 32'(ready), 32'(0));
    repeat (10) @(negedge clk);
    chk("t3_hold_ready", 32'(ready), 32'(0));
    chk("t3_hold_data", 32'(wdata), 32'(16'h1110));
    ack_en = 1'b1;
    send_byte(8'h18);
    send_byte(8'h19);
    idle();
    drain("t3");
    chk("t3_addr", 32'(waddr), 32'(8));

    // Ack timeout and retry of the same word
    ack_en = 1'b0;
    exp_q.push_back({18'd8, 16'hBEEF});
    exp_q.push_back({18'd8, 16'hBEEF});
    send_byte(8'hEF);
    send_byte(8'hBE);
    idle();
    n = 0; hi = 0;
    while (!werr && n < 1000) begin
      @(negedge clk);
      n++;
      if (cmd) hi++;
    end
    chk("t4_err_set", 32'(werr), 32'(1));
    chk("t4_cmd_drop", 32'(cmd), 32'(0));
    chk("t4_addr_hold", 32'(waddr), 32'(8));
    chk("t4_hold_len_ok", 32'(hi >= int'(ACK_TIMEOUT) && hi <= int'(ACK_TIMEOUT) + 1), 32'(1));
    ack_en = 1'b1;
    drain("t4");
    chk("t4_addr", 32'(waddr), 32'(9));
    chk("t4_err_sticky", 32'(werr), 32'(1));

    // Reset during WAIT discards queued words and the partial byte
    ack_en = 1'b0;
    exp_q.push_back({18'd9, 16'h5AC3});
    send_byte(8'hC3);
    send_byte(8'h5A);
    send_byte(8'h77);
    idle();
    n = 0;
    while (!cmd && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("t6_cmd_up", 32'(cmd), 32'(1));
    repeat (2) @(negedge clk);
    rst_a = 1'b1;
    @(negedge clk);
    chk("t6_rst_cmd", 32'(cmd), 32'(0));
    chk("t6_rst_addr", 32'(waddr), 32'(0));
    chk("t6_rst_flags", 32'({mfull, ovf, werr}), 32'(0));
    chk("t6_rst_ready", 32'(ready), 32'(0));
    rst_a = 1'b0;
    ack_en = 1'b1;
    exp_q.push_back({18'd0, 16'h0201});
    send_byte(8'h01);
    send_byte(8'h02);
    idle();
    drain("t6");
    chk("t6_addr", 32'(waddr), 32'(1));

    // Memory full at ADDR_LAST=3 on the second instance
    @(negedge clk);
    rst_a = 1'b1;
    sel   = 1'b1;
    @(negedge clk);
    rst_b = 1'b0;
    for (int i = 0; i < 4; i++)
      exp_q.push_back({18'(i), 8'(8'h21 + 2 * i), 8'(8'h20 + 2 * i)});
    for (int i = 0; i < 10; i++) send_byte(8'(8'h20 + i));
    idle();
    drain("t5");
    repeat (5) @(negedge clk);
    chk("t5_mem_full", 32'(mfull), 32'(1));
    chk("t5_addr", 32'(waddr), 32'(3));
    chk("t5_ready", 32'(ready), 32'(0));
    chk("t5_no_ovf_yet", 32'(ovf), 32'(0));
    byte_in    = 8'hEE;
    byte_valid = 1'b1;
    @(negedge clk);
    byte_valid = 1'b0;
    chk("t5_overflow", 32'(ovf), 32'(1));
    repeat (20) @(negedge clk);
    chk("t5_parked_cmd", 32'(cmd), 32'(0));
    chk("t5_queue_empty", 32'(exp_q.size()), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
